// File: rtl/mux_logic_scheduler.sv
// mux_logic_scheduler
//   Shares a single bit-wide 2:1-mux logic cell among four requesters.
//   A round-robin arbiter grants one request at a time. The granted
//   requester's opcode and operands are latched, and the result is
//   evaluated one bit per clock, LSB first.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a request; arbitrate, grant, latch operands
//   EVAL  | compute one result bit per cycle (WIDTH cycles)
//   DONE  | publish result: res_valid pulse, res_id/res_data update
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        request per requester (bit k = requester k)
//   req_op     3-bit opcode per requester, requester k at [3k+2:3k]
//   req_a      operand A per requester, requester k at slice k
//   req_b      operand B per requester, requester k at slice k
//   gnt        one-hot grant pulse
//   busy       high while evaluating or publishing
//   res_valid  single-cycle result strobe
//   res_id     requester that owns res_data
//   res_data   result word, held until the next result
module mux_logic_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [11:0]        req_op,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               res_valid,
    output logic [1:0]         res_id,
    output logic [WIDTH-1:0]   res_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    state_t           state_q;
    logic [1:0]       last_q;
    logic [1:0]       id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [4:0]       cnt_q;
    logic [3:0]       gnt_q;
    logic             busy_q;
    logic             res_valid_q;
    logic [1:0]       res_id_q;
    logic [WIDTH-1:0] res_data_q;

    logic             found_d;
    logic [1:0]       grant_idx_d;
    logic [1:0]       cand;
    logic             i0;
    logic             i1;
    logic             cell_d;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        found_d     = 1'b0;
        grant_idx_d = last_q;
        cand        = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found_d && req[cand]) begin
                found_d     = 1'b1;
                grant_idx_d = cand;
            end
        end
    end

    // The shared cell: operand bits stream out of the LSB of a_q/b_q,
    // B selects between the two opcode-dependent data inputs.
    always_comb begin
        i0 = 1'b0;
        i1 = 1'b0;
        case (op_q)
            3'd0: begin i0 = 1'b0;     i1 = a_q[0];  end
            3'd1: begin i0 = a_q[0];   i1 = 1'b1;    end
            3'd2: begin i0 = 1'b1;     i1 = 1'b0;    end
            3'd3: begin i0 = 1'b1;     i1 = ~a_q[0]; end
            3'd4: begin i0 = ~a_q[0];  i1 = 1'b0;    end
            3'd5: begin i0 = a_q[0];   i1 = ~a_q[0]; end
            3'd6: begin i0 = ~a_q[0];  i1 = a_q[0];  end
            default: begin i0 = 1'b0;  i1 = 1'b0;    end
        endcase
        cell_d = b_q[0] ? i1 : i0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 2'd3;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q   <= 4'b0001 << grant_idx_d;
                        last_q  <= grant_idx_d;
                        id_q    <= grant_idx_d;
                        op_q    <= req_op[int'(grant_idx_d)*3 +: 3];
                        a_q     <= req_a[int'(grant_idx_d)*WIDTH +: WIDTH];
                        b_q     <= req_b[int'(grant_idx_d)*WIDTH +: WIDTH];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Shift each new bit in at the MSB; after WIDTH shifts
                    // bit 0 has arrived at position 0.
                    acc_q <= (acc_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    res_valid_q <= 1'b1;
                    res_id_q    <= id_q;
                    res_data_q  <= acc_q;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mux_logic_scheduler.sv
`timescale 1ns/1ps
module tb_mux_logic_scheduler;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [11:0]        req_op;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic [3:0]         gnt;
    logic               busy;
    logic               res_valid;
    logic [1:0]         res_id;
    logic [WIDTH-1:0]   res_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mux_logic_scheduler #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[k*3 +: 3]     = op;
        req_a[k*WIDTH +: WIDTH] = a;
        req_b[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 30 && gnt == 4'b0000; i++) tick();
    endtask

    // Waits for the grant, drops req, then measures latency to res_valid.
    task automatic run_req(input string tag, input int idx, input logic [7:0] exp_data);
        int n;
        wait_gnt();
        check({tag, " gnt"}, 32'(gnt), 32'(4'b0001 << idx));
        check({tag, " busy"}, 32'(busy), 32'd1);
        req = 4'b0000;
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " res_id"}, 32'(res_id), 32'(idx));
        check({tag, " res_data"}, 32'(res_data), 32'(exp_data));
        tick();
        check({tag, " pulse"}, 32'(res_valid), 32'd0);
        check({tag, " hold"}, 32'(res_data), 32'(exp_data));
    endtask

    initial begin
        logic [7:0] exp_ops [8];
        int prev;
        int n;
        exp_ops = '{8'h24, 8'hBD, 8'hC3, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h00};

        rst = 1'b1;
        req = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        tick();
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_id", 32'(res_id), 32'd0);
        check("rst res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("idle no req gnt", 32'(gnt), 32'd0);

        // basic AND on requester 0
        set_req(0, 3'd0, 8'hF0, 8'hCC);
        req = 4'b0001;
        run_req("and r0", 0, 8'hC0);

        // all opcodes on requester 2
        for (int op = 0; op < 8; op++) begin
            set_req(2, 3'(op), 8'hA5, 8'h3C);
            req = 4'b0100;
            run_req($sformatf("op%0d r2", op), 2, exp_ops[op]);
        end

        // round-robin with all requesters held from reset
        rst = 1'b1;
        req = 4'b1111;
        tick();
        rst = 1'b0;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt();
            check($sformatf("rr grant %0d", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
            if (g > 0) check($sformatf("rr spacing %0d", g), 32'(cyc - prev), 32'd10);
            prev = cyc;
            tick();
        end
        req = 4'b0000;
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        check("rr drain", 32'(res_valid), 32'd1);
        tick();

        // last grant 0 -> grant 1, then 0101 -> 2, then 0001 -> 0
        set_req(1, 3'd1, 8'h12, 8'h40);
        req = 4'b0010;
        run_req("rr1", 1, 8'h52);
        set_req(2, 3'd0, 8'hFF, 8'h0F);
        req = 4'b0101;
        run_req("rr2", 2, 8'h0F);
        set_req(0, 3'd5, 8'hF0, 8'hCC);
        req = 4'b0001;
        run_req("rr0", 0, 8'h3C);

        // operand change during EVAL must not matter
        set_req(0, 3'd0, 8'hF0, 8'hCC);
        req = 4'b0001;
        wait_gnt();
        check("latch gnt", 32'(gnt), 32'd1);
        req = 4'b0000;
        tick();
        tick();
        set_req(0, 3'd1, 8'h00, 8'hFF);
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        check("latch res_data", 32'(res_data), 32'hC0);
        tick();

        // reset at counter=4 aborts the operation
        set_req(3, 3'd6, 8'h3C, 8'h0F);
        req = 4'b1000;
        wait_gnt();
        check("abort gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("abort gnt0", 32'(gnt), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort res_valid", 32'(res_valid), 32'd0);
        check("abort res_id", 32'(res_id), 32'd0);
        check("abort res_data", 32'(res_data), 32'd0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid) n++;
        end
        check("abort no res_valid", 32'(n), 32'd0);
        req = 4'b1000;
        run_req("after abort", 3, 8'hCC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_logic_scheduler.md
MUX_LOGIC_SCHEDULER -- requirements
Module: mux_logic_scheduler

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits, serially evaluated; legal range 1-16.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester request, bit k = requester k.
REQ-005 Port: req_op  input  12  3-bit opcode per requester, requester k at bits [3k+2:3k].
REQ-006 Port: req_a  input  4*WIDTH  operand A per requester, requester k at slice k.
REQ-007 Port: req_b  input  4*WIDTH  operand B per requester, requester k at slice k.
REQ-008 Port: gnt  output  4  one-hot, single-cycle pulse when a request is accepted.
REQ-009 Port: busy  output  1  high while in EVAL or DONE.
REQ-010 Port: res_valid  output  1  single-cycle pulse, result available.
REQ-011 Port: res_id  output  2  index of requester owning the result.
REQ-012 Port: res_data  output  WIDTH  result word.

Function
REQ-013 Block SHALL share one bit-wide 2:1-mux logic cell among 4 requesters, evaluating one result bit per clock.
REQ-014 Opcodes SHALL be 0 AND, 1 OR, 2 NOT (~B), 3 NAND, 4 NOR, 5 XOR, 6 XNOR; opcode 7 SHALL yield all-zero result.
REQ-015 Bit i SHALL equal mux(i0, i1, sel=B[i]) with (i0,i1): AND (0,A), OR (A,1), NOT (1,0), NAND (1,~A), NOR (~A,0), XOR (A,~A), XNOR (~A,A), using A[i].
REQ-016 FSM states SHALL be IDLE, EVAL, DONE.
REQ-017 IDLE: if req nonzero, block SHALL select one requester round-robin, starting search at (last_grant+1) mod 4, pulse its gnt bit, latch its op/A/B and index, clear bit counter, enter EVAL.
REQ-018 IDLE with req = 0 SHALL stay in IDLE, gnt = 0.
REQ-019 EVAL: each cycle SHALL compute bit[counter] into result register, LSB first; after bit WIDTH-1, enter DONE.
REQ-020 DONE: res_valid SHALL be 1 for exactly one cycle with res_id and res_data valid; next state IDLE.
REQ-021 Latency: gnt in cycle T SHALL give res_valid in cycle T+WIDTH+1; back-to-back throughput one result per WIDTH+2 cycles.
REQ-022 last_grant SHALL update to the granted index in the grant cycle only.
REQ-023 Requests arriving or dropping while busy SHALL be ignored; only req sampled in IDLE counts.
REQ-024 Operands/opcode SHALL be taken only from the grant cycle; later changes on req_* SHALL not affect the result.
REQ-025 res_data and res_id SHALL hold their last values until the next DONE.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 On rst high, block SHALL immediately enter IDLE: gnt=0, busy=0, res_valid=0, res_id=0, res_data=0, counter=0, last_grant=3 (requester 0 has first priority).
REQ-028 Reset asserted mid-EVAL SHALL abort the operation with no res_valid pulse afterwards.

Verification
REQ-029 WIDTH=8, req=0001, op0=0, A=0xF0, B=0xCC -> gnt=0001 at T, res_valid at T+9, res_id=0, res_data=0xC0.
REQ-030 All 7 opcodes on requester 2, A=0xA5, B=0x3C -> 0x24, 0xBD, 0xC3, 0xDB, 0x42, 0x99, 0x66; opcode 7 -> 0x00.
REQ-031 req=1111 held continuously from reset -> grants 0,1,2,3,0 in order, gnt pulses spaced 10 cycles.
REQ-032 After grant to 1, req=0101 -> next grant 2; then req=0001 -> grant 0.
REQ-033 Change req_a/req_b of granted requester during EVAL -> result reflects grant-cycle operands.
REQ-034 Assert rst at counter=4 -> all outputs 0 immediately, no res_valid, next req=1000 granted with normal latency.
